bcd_to_7segment: RTL and testbench

Registered BCD-to-seven-segment decoder for a single display digit. It samples a 4-bit BCD code with a valid qualifier and drives the segment lines one clock later. It also provides lamp-test, blanking and an error flag for codes 10-15. It sits between the numeric datapath and the display pin drivers.

---
 rtl/bcd_to_7segment.sv | 114 +++++++++++
 tb/tb_bcd_to_7segment.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/bcd_to_7segment.sv
// Registered BCD-to-seven-segment decoder with lamp-test, blanking and error flag.
// Optional macro HEX_DIGITS_EN: codes 10-15 show hex glyphs A b C d E F instead of flagging an error.
module bcd_to_7segment #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] bcd,
    input  logic       bcd_valid,
    input  logic       lamp_test,
    input  logic       blank,
    output logic [6:0] seg,
    output logic       seg_valid,
    output logic       err
);

    localparam logic [6:0] POL_MASK = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

    // Active-high glyph for a code, a..g MSB to LSB.
    function automatic logic [6:0] decode_glyph(input logic [3:0] code);
        logic [6:0] glyph;
        case (code)
            4'd0:    glyph = 7'b1111110;
            4'd1:    glyph = 7'b0110000;
            4'd2:    glyph = 7'b1101101;
            4'd3:    glyph = 7'b1111001;
            4'd4:    glyph = 7'b0110011;
            4'd5:    glyph = 7'b1011011;
            4'd6:    glyph = 7'b1011111;
            4'd7:    glyph = 7'b1110000;
            4'd8:    glyph = 7'b1111111;
            4'd9:    glyph = 7'b1111011;
`ifdef HEX_DIGITS_EN
            4'd10:   glyph = 7'b1110111;
            4'd11:   glyph = 7'b0011111;
            4'd12:   glyph = 7'b1001110;
            4'd13:   glyph = 7'b0111101;
            4'd14:   glyph = 7'b1001111;
            4'd15:   glyph = 7'b1000111;
`endif
            default: glyph = 7'b0000000;
        endcase
        return glyph;
    endfunction

    // True when a sampled code is outside the displayable set.
    function automatic logic code_is_err(input logic [3:0] code);
`ifdef HEX_DIGITS_EN
        return 1'b0 & code[0];
`else
        return (code > 4'd9) ? 1'b1 : 1'b0;
`endif
    endfunction

    logic [3:0] code_r;
    logic       seg_valid_r;
    logic       err_r;
    logic [6:0] seg_r;

    logic [3:0] code_next_s;
    logic       have_code_s;
    logic [6:0] seg_raw_s;
    logic [6:0] seg_next_s;

    // Next segment pattern: overrides first, then the held (or just-captured) code.
    always_comb begin
        code_next_s = code_r;
        have_code_s = seg_valid_r;
        seg_raw_s   = 7'b0000000;
        if (bcd_valid) begin
            code_next_s = bcd;
            have_code_s = 1'b1;
        end else begin
            code_next_s = code_r;
            have_code_s = seg_valid_r;
        end
        if (lamp_test) begin
            seg_raw_s = 7'b1111111;
        end else if (blank) begin
            seg_raw_s = 7'b0000000;
        end else if (have_code_s) begin
            seg_raw_s = decode_glyph(code_next_s);
        end else begin
            seg_raw_s = 7'b0000000;
        end
        seg_next_s = seg_raw_s ^ POL_MASK;
    end

    // Code capture, status flags and polarity-adjusted segment register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_r      <= 4'd0;
            seg_valid_r <= 1'b0;
            err_r       <= 1'b0;
            seg_r       <= POL_MASK;
        end else begin
            if (bcd_valid) begin
                code_r      <= bcd;
                seg_valid_r <= 1'b1;
                err_r       <= code_is_err(bcd);
            end else begin
                code_r      <= code_r;
                seg_valid_r <= seg_valid_r;
                err_r       <= err_r;
            end
            seg_r <= seg_next_s;
        end
    end

    assign seg       = seg_r;
    assign seg_valid = seg_valid_r;
    assign err       = err_r;

endmodule

// File: tb/tb_bcd_to_7segment.sv
// Randomized self-checking bench for bcd_to_7segment (both output polarities).
module tb_bcd_to_7segment;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] bcd = 4'd0;
    logic       bcd_valid = 1'b0;
    logic       lamp_test = 1'b0;
    logic       blank = 1'b0;
    logic [6:0] seg, seg_n;
    logic       seg_valid, err, seg_valid_n, err_n;

    int tests_run = 0;
    int tests_failed = 0;

    logic [6:0] glyph [16];
    logic [3:0] m_code;
    bit         m_has;
    bit         m_err;
    logic [6:0] m_seg;

    bcd_to_7segment #(.ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .bcd(bcd), .bcd_valid(bcd_valid),
        .lamp_test(lamp_test), .blank(blank),
        .seg(seg), .seg_valid(seg_valid), .err(err)
    );

    bcd_to_7segment #(.ACTIVE_LOW(1'b1)) dut_n (
        .clk(clk), .rst_n(rst_n), .bcd(bcd), .bcd_valid(bcd_valid),
        .lamp_test(lamp_test), .blank(blank),
        .seg(seg_n), .seg_valid(seg_valid_n), .err(err_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_code = 4'd0;
        m_has  = 1'b0;
        m_err  = 1'b0;
        m_seg  = 7'b0000000;
    endtask

    task automatic check_all(input string tag);
        logic [6:0] inv;
        inv = ~m_seg;
        check({tag, ".seg"},        32'(seg),         32'(m_seg));
        check({tag, ".seg_n"},      32'(seg_n),       32'(inv));
        check({tag, ".seg_valid"},  32'(seg_valid),   32'(m_has));
        check({tag, ".err"},        32'(err),         32'(m_err));
        check({tag, ".seg_valid_n"},32'(seg_valid_n), 32'(m_has));
        check({tag, ".err_n"},      32'(err_n),       32'(m_err));
    endtask

    // One clock: model what the display should show after this edge, then compare.
    task automatic step(input string tag);
        @(posedge clk);
        if (rst_n) begin
            if (bcd_valid) begin
                m_code = bcd;
                m_has  = 1'b1;
`ifdef HEX_DIGITS_EN
                m_err  = 1'b0;
`else
                m_err  = (int'(bcd) >= 10);
`endif
            end
            if (lamp_test)  m_seg = 7'b1111111;
            else if (blank) m_seg = 7'b0000000;
            else if (m_has) m_seg = glyph[m_code];
            else            m_seg = 7'b0000000;
        end
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic [3:0] b, input logic v, input logic lt, input logic bl);
        bcd = b; bcd_valid = v; lamp_test = lt; blank = bl;
    endtask

    initial begin
        glyph[0] = 7'b1111110; glyph[1] = 7'b0110000; glyph[2] = 7'b1101101;
        glyph[3] = 7'b1111001; glyph[4] = 7'b0110011; glyph[5] = 7'b1011011;
        glyph[6] = 7'b1011111; glyph[7] = 7'b1110000; glyph[8] = 7'b1111111;
        glyph[9] = 7'b1111011;
`ifdef HEX_DIGITS_EN
        glyph[10] = 7'b1110111; glyph[11] = 7'b0011111; glyph[12] = 7'b1001110;
        glyph[13] = 7'b0111101; glyph[14] = 7'b1001111; glyph[15] = 7'b1000111;
`else
        for (int i = 10; i < 16; i++) glyph[i] = 7'b0000000;
`endif
        model_reset();

        // Reset held across edges, then the first edge with no sample keeps seg off.
        @(posedge clk); @(posedge clk); #1;
        check_all("reset");
        check("reset.seg_n_const", 32'(seg_n), 32'h7f);
        rst_n = 1'b1;
        step("post_reset_idle");

        for (int i = 0; i < 10; i++) begin
            drive(4'(i), 1'b1, 1'b0, 1'b0);
            step("sweep");
            if (i == 4) check("sweep4_const", 32'(seg), 32'h33);
            if (i == 9) check("sweep9_const", 32'(seg), 32'h7b);
        end

        for (int i = 10; i < 16; i++) begin
            drive(4'(i), 1'b1, 1'b0, 1'b0);
            step("invalid");
        end
        drive(4'd3, 1'b1, 1'b0, 1'b0);
        step("recover3");
        check("recover3_const", 32'(seg), 32'h79);

        drive(4'd7, 1'b1, 1'b0, 1'b0);
        step("hold_load");
        for (int i = 0; i < 5; i++) begin
            drive(4'd2, 1'b0, 1'b0, 1'b0);
            step("hold");
        end
        check("hold_const", 32'(seg), 32'h70);

        drive(4'd5, 1'b1, 1'b0, 1'b0); step("ovr_load");
        drive(4'd5, 1'b0, 1'b0, 1'b1); step("ovr_blank");
        drive(4'd5, 1'b0, 1'b1, 1'b1); step("ovr_both");
        drive(4'd5, 1'b0, 1'b0, 1'b0); step("ovr_release");
        check("ovr_release_const", 32'(seg), 32'h5b);

        drive(4'd6, 1'b1, 1'b1, 1'b0); step("simul_capture");
        drive(4'd1, 1'b0, 1'b0, 1'b0); step("simul_release");

        for (int n = 0; n < 300; n++) begin
            drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0));
            step("random");
        end

        // Asynchronous reset between edges while showing 8.
        drive(4'd8, 1'b1, 1'b0, 1'b0); step("async_load");
        drive(4'd8, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        step("async_held");
        rst_n = 1'b1;
        step("async_release_idle");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
